// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter-based debounce FSM, one-cycle press pulse.
// Optional one-shot long-press pulse is compiled in with KEY_LONG_PRESS_EN.
module key_debounce #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter logic [31:0] LONG_CYCLES     = 32'd100000000
) (
  input  logic Sys_CLK,
  input  logic Sys_RST,
  input  logic Key_Raw,
  output logic Key_Pulse,
  output logic Key_Level,
  output logic Key_Long
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [31:0] DEB_LAST = DEBOUNCE_CYCLES - 32'd1;

  state_t      state_q, state_d;
  logic        s1_q, s2_q;
  logic        k;
  logic [31:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;
  logic        level_q, level_d;

  // Synchronizer flops come out of reset at the released raw level.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      s1_q <= ACTIVE_LOW;
      s2_q <= ACTIVE_LOW;
    end else begin
      s1_q <= Key_Raw;
      s2_q <= s1_q;
    end
  end

  assign k = s2_q ^ ACTIVE_LOW;

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (k) begin
          state_d = PRESS_WAIT;
          cnt_d   = 32'd0;
        end
      end
      PRESS_WAIT: begin
        if (!k) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!k) begin
          state_d = RELEASE_WAIT;
          cnt_d   = 32'd0;
        end
      end
      RELEASE_WAIT: begin
        level_d = 1'b1;
        if (k) begin
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
        level_d = 1'b0;
      end
    endcase
  end

  assign Key_Pulse = pulse_q;
  assign Key_Level = level_q;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [31:0] LONG_LAST = LONG_CYCLES - 32'd1;

  logic [31:0] lcnt_q, lcnt_d;
  logic        fired_q, fired_d;
  logic        long_q, long_d;

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      lcnt_q  <= 32'd0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      lcnt_q  <= lcnt_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  // Keyed off the main FSM transitions; release bounce back into PRESSED holds lcnt and fired.
  always_comb begin
    lcnt_d  = lcnt_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (state_q == PRESS_WAIT && state_d == PRESSED) begin
      lcnt_d = 32'd0;
    end else if (state_q == PRESSED && k) begin
      if (lcnt_q == LONG_LAST && !fired_q) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end else if (lcnt_q != 32'hFFFF_FFFF) begin
        lcnt_d = lcnt_q + 32'd1;
      end
    end else if (state_q == RELEASE_WAIT && state_d == IDLE) begin
      fired_d = 1'b0;
    end
  end

  assign Key_Long = long_q;
`else
  logic unused_long_cycles;
  assign unused_long_cycles = ^LONG_CYCLES;
  assign Key_Long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1).
// Per-edge vector table plus a hand-written mid-press reset sequence.
module tb_key_debounce;

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic Sys_CLK = 1'b0;
  logic Sys_RST;
  logic Key_Raw;
  logic Key_Pulse, Key_Level, Key_Long;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Sys_CLK = ~Sys_CLK;

  key_debounce #(
    .DEBOUNCE_CYCLES(32'd4),
    .ACTIVE_LOW     (1'b1),
    .LONG_CYCLES    (32'd10)
  ) dut (
    .Sys_CLK  (Sys_CLK),
    .Sys_RST  (Sys_RST),
    .Key_Raw  (Key_Raw),
    .Key_Pulse(Key_Pulse),
    .Key_Level(Key_Level),
    .Key_Long (Key_Long)
  );

  typedef struct {
    logic rst_n;
    logic raw;
    logic pulse;
    logic level;
    logic lng;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst_n, input logic raw,
                              input logic pulse, input logic level, input logic lng);
    vec_t v;
    v.rst_n = rst_n;
    v.raw   = raw;
    v.pulse = pulse;
    v.level = level;
    v.lng   = lng;
    vecs.push_back(v);
  endfunction

  // Key held pressed for n edges from IDLE: pulse/level at edge 7, long 10 edges later.
  function automatic void add_press(input int n);
    for (int j = 1; j <= n; j++)
      add(1'b1, 1'b0, j == 7, j >= 7, LONG_EN && (j == 17));
  endfunction

  // Key released for n edges from PRESSED: level falls at edge 7.
  function automatic void add_release(input int n);
    for (int j = 1; j <= n; j++)
      add(1'b1, 1'b1, 1'b0, j < 7, 1'b0);
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [0:9] pat;
    logic [0:2] rb;
    int first_pulse;
    int pulses;

    // Reset hold with key pressed, then release reset and keep holding (long-press window).
    for (int j = 0; j < 3; j++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_press(30);
    add_release(10);
    // Clean press.
    add_press(20);
    // Release bounce 1,0,1 then pressed again: level stays, no pulse, no new long.
    rb = 3'b101;
    for (int j = 0; j < 3; j++) add(1'b1, rb[j], 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 10; j++) add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add_release(10);
    // Press bounce: last glitch sample leaves k at edge 7, press accepted at edge 12.
    pat = 10'b0100100000;
    for (int j = 1; j <= 25; j++)
      add(1'b1, (j <= 10) ? pat[j-1] : 1'b0, j == 12, j >= 12, LONG_EN && (j == 22));
    add_release(10);

    Sys_RST = 1'b1;
    Key_Raw = 1'b1;
    #1 Sys_RST = 1'b0;
    #1;
    check("reset_pulse", 0, Key_Pulse, 1'b0);
    check("reset_level", 0, Key_Level, 1'b0);
    check("reset_long",  0, Key_Long,  1'b0);

    foreach (vecs[i]) begin
      @(negedge Sys_CLK);
      Sys_RST = vecs[i].rst_n;
      Key_Raw = vecs[i].raw;
      @(posedge Sys_CLK);
      #1;
      $display("vec %0d: rst=%b raw=%b -> pulse=%b level=%b long=%b", i,
               vecs[i].rst_n, vecs[i].raw, Key_Pulse, Key_Level, Key_Long);
      check("pulse", i, Key_Pulse, vecs[i].pulse);
      check("level", i, Key_Level, vecs[i].level);
      check("long",  i, Key_Long,  vecs[i].lng);
    end

    // Mid-press reset: reach PRESS_WAIT with cnt=2, then reset asynchronously.
    for (int e = 1; e <= 5; e++) begin
      @(negedge Sys_CLK);
      Key_Raw = 1'b0;
      @(posedge Sys_CLK);
      #1;
      $display("midrst pre edge %0d: pulse=%b level=%b", e, Key_Pulse, Key_Level);
      check("midrst_pre_pulse", e, Key_Pulse, 1'b0);
      check("midrst_pre_level", e, Key_Level, 1'b0);
    end
    #2 Sys_RST = 1'b0;
    #1;
    $display("midrst asserted: pulse=%b level=%b long=%b", Key_Pulse, Key_Level, Key_Long);
    check("midrst_now_pulse", 0, Key_Pulse, 1'b0);
    check("midrst_now_level", 0, Key_Level, 1'b0);
    check("midrst_now_long",  0, Key_Long,  1'b0);
    for (int e = 1; e <= 2; e++) begin
      @(posedge Sys_CLK);
      #1;
      check("midrst_hold_pulse", e, Key_Pulse, 1'b0);
    end
    @(negedge Sys_CLK);
    Sys_RST = 1'b1;
    first_pulse = 0;
    pulses = 0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge Sys_CLK);
      #1;
      if (Key_Pulse === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = e;
      end
    end
    $display("midrst after release: first pulse edge %0d, pulse count %0d", first_pulse, pulses);
    n_checks++;
    if (first_pulse != 7) begin
      n_errors++;
      $display("FAIL midrst_pulse_edge: got %0d expected 7", first_pulse);
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL midrst_pulse_count: got %0d expected 1", pulses);
    end
    check("midrst_level", 15, Key_Level, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioner for a mechanical push-button feeding the light controller's `Key_In` input. It synchronizes the raw key into `Sys_CLK`, rejects contact bounce with a counter-based filter, and emits exactly one single-cycle `Key_Pulse` per physical press. Optionally, it also emits a one-shot long-press pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronized cycles required to accept a press or a release (20 ms at 50 MHz); legal range 2 to 2^32-1.
- `ACTIVE_LOW`, default 1: 1 means the raw key reads 0 when pressed; 0 means the raw key reads 1 when pressed.
- `LONG_CYCLES`, default 100000000: cycles in the accepted-pressed state before `Key_Long` fires (2 s). Used only with `KEY_LONG_PRESS_EN`; legal range 2 to 2^32-1.
- `Sys_CLK`, input, 1: system clock.
- `Sys_RST`, input, 1: asynchronous, active-low reset.
- `Key_Raw`, input, 1: raw, asynchronous, bouncing button level.
- `Key_Pulse`, output, 1: one-cycle, active-high pulse per accepted press. Drives the controller's `Key_In`.
- `Key_Level`, output, 1: debounced, active-high pressed level.
- `Key_Long`, output, 1: one-cycle, active-high long-press pulse. Tied to 0 when the feature is compiled out.

## Operation
- **Synchronizer.** Two flops, `s1` then `s2`. Both reset to the released raw level: 1 if `ACTIVE_LOW`, else 0.
- **Normalized key.** `k = s2 ^ ACTIVE_LOW`, so `k` is 1 when the key is pressed. All FSM decisions use `k` only.
- **Counters.** 32-bit `cnt`, which never wraps: it stops at `DEBOUNCE_CYCLES-1`. With the macro, a 32-bit `lcnt`.
- **FSM states.** `IDLE`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`. Reset state is `IDLE`.
- **`IDLE`:**
  - `Key_Level` = 0.
  - `k` = 1 → go to `PRESS_WAIT`, `cnt` ← 0.
- **`PRESS_WAIT`:**
  - `k` = 0 → go to `IDLE`. This is a glitch; no output changes.
  - Else, if `cnt == DEBOUNCE_CYCLES-1` → go to `PRESSED`, set `Key_Level` ← 1 and `Key_Pulse` ← 1 for one cycle, `lcnt` ← 0.
  - Else `cnt` ← `cnt` + 1.
- **`PRESSED`:**
  - `k` = 0 → go to `RELEASE_WAIT`, `cnt` ← 0.
  - With the macro, while `k` = 1: if `lcnt == LONG_CYCLES-1` and long-press has not yet fired → `Key_Long` ← 1 for one cycle and set the fired flag; else `lcnt` ← `lcnt` + 1, saturating.
- **`RELEASE_WAIT`:**
  - `Key_Level` stays 1.
  - `k` = 1 → go back to `PRESSED`. This is release bounce: no new `Key_Pulse`, and `lcnt` and the fired flag are held.
  - Else, if `cnt == DEBOUNCE_CYCLES-1` → go to `IDLE`, `Key_Level` ← 0, clear the fired flag.
  - Else `cnt` ← `cnt` + 1.
- **Unreachable state encodings** → `IDLE` with all outputs 0.
- **Ordering guarantee.** `Key_Pulse` and `Key_Long` are never asserted in the same cycle. `Key_Long` can only follow `Key_Pulse` by at least `LONG_CYCLES` cycles.

## Timing
- **Reset values.** `Key_Pulse` = 0, `Key_Level` = 0, `Key_Long` = 0, `cnt` = 0, `lcnt` = 0, fired flag = 0, state = `IDLE`.
- **Reset mid-operation.** Asserting reset at any point returns to these values immediately. No pulse is emitted on release of reset, even if the key is held at that time.
- **Press latency.** Edge 1 samples an active, stable `Key_Raw`. `Key_Pulse` is registered high at edge `DEBOUNCE_CYCLES+3`, together with `Key_Level` rising. `Key_Pulse` is high for exactly one cycle.
- **Release latency.** `Key_Level` falls at edge `DEBOUNCE_CYCLES+3` after the first edge sampling an inactive, stable key.
- **Bounce rejection.** Any inactive sample of `k` in `PRESS_WAIT` restarts qualification. The next accepted press needs a full `DEBOUNCE_CYCLES` window again.
- **Long press.** `Key_Long` is registered high `LONG_CYCLES` cycles after the edge that raised `Key_Pulse`, counting only cycles with `k` = 1.
- **All outputs are registered.** There is no combinational path from `Key_Raw`.

## Configuration
- **Macro:** `KEY_LONG_PRESS_EN`.
- **Defined:** `lcnt`, the fired flag, and the `Key_Long` logic are compiled in, behaving as described above.
- **Undefined:** that logic is removed, `Key_Long` is driven constant 0, and `LONG_CYCLES` is ignored. `Key_Pulse` and `Key_Level` behaviour is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `ACTIVE_LOW`=1.
- **Reset hold.** Hold `Sys_RST`=0 with `Key_Raw`=0 (pressed), then release reset and keep the key pressed. Required: all outputs stay 0 while in reset; after release, `Key_Pulse` fires exactly once, at edge 7 after the first post-reset edge.
- **Clean press.** Drive `Key_Raw` 1→0 and hold for 20 cycles. Required: one-cycle `Key_Pulse` at edge 7; `Key_Level` goes 1 at edge 7 and stays 1.
- **Press bounce.** Pattern 0,1,0,0,1,0,0,0,0,0, then held at 0. Required: exactly one `Key_Pulse`, no earlier than 4 stable synchronized cycles after the last 1 is cleared from the synchronizer.
- **Release bounce.** While accepted as pressed, drive 1,0,1 (each held 1 cycle), then 0 again for 10 cycles. Required: `Key_Level` stays 1 throughout and no second `Key_Pulse`.
- **Long press.** Build with `KEY_LONG_PRESS_EN`, hold the key for 30 cycles. Required: one `Key_Long` pulse 10 cycles after `Key_Pulse`, none afterwards. Build without the macro: `Key_Long` stays 0.
- **Mid-press reset.** Assert reset while in `PRESS_WAIT` with `cnt`=2. Required: no `Key_Pulse`; all outputs 0 immediately; after reset release with the key still held, qualification restarts from `cnt`=0.
